// File: rtl/ball_step_ctrl.sv
// Frame-stepped ball controller for a paddle game: the ball advances once per
// VGA frame, bounces off the walls and the paddle, and reports hits and misses.
module ball_step_ctrl #(
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int BALL     = 8,
    parameter int SPEED    = 4,
    parameter int PADDLE_W = 64,
    parameter int PADDLE_H = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       verticalSync,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] paddle_col,
    input  logic [9:0] paddle_row,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic [7:0] hit_count
);

    localparam logic [10:0] X_MAX   = 11'(COLS - BALL);
    localparam logic [10:0] Y_MAX   = 11'(ROWS - BALL);
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [10:0] BSZ     = 11'(BALL);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [9:0]  X_HOME  = 10'(COLS / 2 - BALL / 2);
    localparam logic [9:0]  Y_HOME  = 10'(ROWS / 2 - BALL / 2);
    localparam logic [9:0]  X_LIMIT = 10'(COLS - BALL);
    localparam logic [9:0]  Y_LIMIT = 10'(ROWS - BALL);
    localparam logic [9:0]  SPD10   = 10'(SPEED);
    localparam logic [9:0]  BSZ10   = 10'(BALL);

    typedef enum logic [2:0] {IDLE, WAIT_FRAME, MOVE, HIT_CHK, MISS} state_t;

    state_t     state, state_n;
    logic       vs_meta, vs_sync, vs_prev;
    logic       frame_tick;
    logic [9:0] x_q, y_q, x_n, y_n;
    logic       dir_x, dir_y, dir_x_n, dir_y_n;
    logic [7:0] count_q, count_n;
    logic       hit_q, hit_n;
    logic [10:0] x_add, y_add, y_bot, x_right, p_bot, p_right;
    logic       paddle_hit;

    // vsync is asynchronous; a third flop gives the edge detector its history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= verticalSync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_prev & ~vs_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            x_q     <= X_HOME;
            y_q     <= Y_HOME;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
            count_q <= 8'd0;
            hit_q   <= 1'b0;
        end else begin
            state   <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            dir_x   <= dir_x_n;
            dir_y   <= dir_y_n;
            count_q <= count_n;
            hit_q   <= hit_n;
        end
    end

    // Sums are 11 bits wide so nothing wraps near the right and bottom edges
    assign x_add   = {1'b0, x_q} + SPD;
    assign y_add   = {1'b0, y_q} + SPD;
    assign y_bot   = {1'b0, y_q} + BSZ;
    assign x_right = {1'b0, x_q} + BSZ;
    assign p_bot   = {1'b0, paddle_row} + PH;
    assign p_right = {1'b0, paddle_col} + PW;

    assign paddle_hit = dir_y
                      && (y_bot >= {1'b0, paddle_row})
                      && ({1'b0, y_q} < p_bot)
                      && (x_right > {1'b0, paddle_col})
                      && ({1'b0, x_q} < p_right);

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        count_n = count_q;
        hit_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT_FRAME;
                    count_n = 8'd0;
                end
            end
            WAIT_FRAME: begin
                if (frame_tick && !pause) state_n = MOVE;
            end
            MOVE: begin
                if (dir_x) begin
                    if (x_add >= X_MAX) begin
                        x_n     = X_LIMIT;
                        dir_x_n = 1'b0;
                    end else begin
                        x_n = x_add[9:0];
                    end
                end else if (x_q < SPD10) begin
                    x_n     = 10'd0;
                    dir_x_n = 1'b1;
                end else begin
                    x_n = x_q - SPD10;
                end
                // Reaching the floor keeps dir_y so the miss check can see it
                if (!dir_y) begin
                    if (y_q < SPD10) begin
                        y_n     = 10'd0;
                        dir_y_n = 1'b1;
                    end else begin
                        y_n = y_q - SPD10;
                    end
                end else if (y_add >= Y_MAX) begin
                    y_n = Y_LIMIT;
                end else begin
                    y_n = y_add[9:0];
                end
                state_n = HIT_CHK;
            end
            HIT_CHK: begin
                if (paddle_hit) begin
                    y_n     = (paddle_row >= BSZ10) ? paddle_row - BSZ10 : 10'd0;
                    dir_y_n = 1'b0;
                    hit_n   = 1'b1;
                    count_n = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                    state_n = WAIT_FRAME;
                end else if (y_q == Y_LIMIT) begin
                    state_n = MISS;
                end else begin
                    state_n = WAIT_FRAME;
                end
            end
            MISS: begin
                x_n     = X_HOME;
                y_n     = Y_HOME;
                dir_x_n = 1'b1;
                dir_y_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign busy      = (state != IDLE);
    assign hit       = hit_q;
    assign miss      = (state == MISS);
    assign hit_count = count_q;

endmodule

// File: tb/tb_ball_step_ctrl.sv
// Directed bench for ball_step_ctrl: drives vsync frames, start, pause and the
// paddle, and checks ball position and status against hand-worked values.
module tb_ball_step_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vertical_sync;
    logic       start;
    logic       pause;
    logic [9:0] paddle_col;
    logic [9:0] paddle_row;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       busy;
    logic       hit;
    logic       miss;
    logic [7:0] hit_count;

    int checks = 0;
    int passed = 0;
    int hit_pulses = 0;
    int miss_pulses = 0;
    int overlap = 0;
    logic       miss_prev = 1'b0;
    logic [9:0] post_miss_x = '0;
    logic [9:0] post_miss_y = '0;
    logic       post_miss_busy = 1'b1;

    ball_step_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .verticalSync (vertical_sync),
        .start        (start),
        .pause        (pause),
        .paddle_col   (paddle_col),
        .paddle_row   (paddle_row),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .busy         (busy),
        .hit          (hit),
        .miss         (miss),
        .hit_count    (hit_count)
    );

    always #10 clk = ~clk;

    // Pulse widths are measured in cycles, and the cycle after a miss is captured
    always @(negedge clk) begin
        if (hit) hit_pulses++;
        if (miss) miss_pulses++;
        if (hit && miss) overlap++;
        if (miss_prev) begin
            post_miss_x    = ball_x;
            post_miss_y    = ball_y;
            post_miss_busy = busy;
        end
        miss_prev = miss;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic applyStimulus(input int frames);
        repeat (frames) begin
            vertical_sync = 1'b0;
            repeat (8) @(negedge clk);
            vertical_sync = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic trackPaddle();
        paddle_col = (ball_x >= 10'd16) ? ball_x - 10'd16 : 10'd0;
        paddle_row = (ball_y > 10'd8) ? ball_y + 10'd8 : 10'd8;
    endtask

    initial begin
        int frames;
        int base;
        reset_n       = 1'b0;
        vertical_sync = 1'b1;
        start         = 1'b0;
        pause         = 1'b0;
        paddle_col    = 10'd0;
        paddle_row    = 10'd470;
        repeat (3) @(negedge clk);

        checkOutput("reset_x", ball_x, 316);
        checkOutput("reset_y", ball_y, 236);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_hit", hit, 0);
        checkOutput("reset_miss", miss, 0);
        checkOutput("reset_count", hit_count, 0);

        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(1);
        checkOutput("no_start_y", ball_y, 236);
        checkOutput("no_start_busy", busy, 0);

        pulseStart();
        checkOutput("start_busy", busy, 1);
        applyStimulus(3);
        checkOutput("three_x", ball_x, 328);
        checkOutput("three_y", ball_y, 248);
        checkOutput("three_busy", busy, 1);
        checkOutput("three_hits", hit_pulses, 0);
        checkOutput("three_misses", miss_pulses, 0);

        applyStimulus(55);
        checkOutput("pre_hit_x", ball_x, 548);
        checkOutput("pre_hit_y", ball_y, 468);

        paddle_col = 10'd538;
        paddle_row = 10'd476;
        applyStimulus(1);
        checkOutput("hit_x", ball_x, 552);
        checkOutput("hit_y", ball_y, 468);
        checkOutput("hit_pulse_cycles", hit_pulses, 1);
        checkOutput("hit_count_one", hit_count, 1);
        checkOutput("hit_no_miss", miss_pulses, 0);

        applyStimulus(19);
        checkOutput("wall_approach_x", ball_x, 628);
        checkOutput("wall_approach_y", ball_y, 392);
        applyStimulus(1);
        checkOutput("wall_clamp_x", ball_x, 632);
        applyStimulus(1);
        checkOutput("wall_return_x", ball_x, 628);
        checkOutput("wall_return_y", ball_y, 384);

        pause = 1'b1;
        applyStimulus(5);
        pulseStart();
        applyStimulus(1);
        checkOutput("pause_x", ball_x, 628);
        checkOutput("pause_y", ball_y, 384);
        checkOutput("pause_count", hit_count, 1);
        checkOutput("pause_busy", busy, 1);
        pause = 1'b0;
        applyStimulus(1);
        checkOutput("resume_x", ball_x, 624);
        checkOutput("resume_y", ball_y, 380);

        paddle_col = 10'd0;
        paddle_row = 10'd0;
        frames = 0;
        while (miss_pulses == 0 && frames < 300) begin
            applyStimulus(1);
            frames++;
        end
        checkOutput("miss_frames", frames, 214);
        checkOutput("miss_pulse_cycles", miss_pulses, 1);
        checkOutput("post_miss_x", post_miss_x, 316);
        checkOutput("post_miss_y", post_miss_y, 236);
        checkOutput("post_miss_busy", post_miss_busy, 0);
        checkOutput("miss_count_kept", hit_count, 1);

        applyStimulus(2);
        checkOutput("idle_hold_x", ball_x, 316);
        checkOutput("idle_hold_y", ball_y, 236);
        checkOutput("idle_busy", busy, 0);

        pulseStart();
        checkOutput("restart_count", hit_count, 0);
        base = hit_pulses;
        frames = 0;
        while (hit_count != 8'd255 && frames < 600) begin
            trackPaddle();
            applyStimulus(1);
            frames++;
        end
        checkOutput("sat_count", hit_count, 255);
        checkOutput("sat_hits", hit_pulses - base, 255);
        trackPaddle();
        applyStimulus(1);
        checkOutput("sat_extra_hits", hit_pulses - base, 256);
        checkOutput("sat_hold", hit_count, 255);
        checkOutput("sat_no_miss", miss_pulses, 1);

        @(negedge clk);
        vertical_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_x", ball_x, 316);
        checkOutput("async_rst_y", ball_y, 236);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_hit", hit, 0);
        checkOutput("async_rst_miss", miss, 0);
        checkOutput("async_rst_count", hit_count, 0);

        @(negedge clk);
        vertical_sync = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1);
        checkOutput("post_rst_y", ball_y, 236);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("hit_miss_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ball_step_ctrl.md
BALL_STEP_CTRL -- requirements
Module: ball_step_ctrl

Interface
REQ-001 Parameter COLS, default 640, active display width in pixels.
REQ-002 Parameter ROWS, default 480, active display height in pixels.
REQ-003 Parameter BALL, default 8, ball edge length in pixels (square).
REQ-004 Parameter SPEED, default 4, pixels moved per axis per step.
REQ-005 Parameter PADDLE_W, default 64, paddle width in pixels; PADDLE_H, default 8, paddle height in pixels.
REQ-006 clk  input  1  system clock (50 MHz).
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 verticalSync  input  1  VGA vsync, active-low, asynchronous to clk.
REQ-009 start  input  1  one-cycle pulse, launches play.
REQ-010 pause  input  1  level; high freezes motion.
REQ-011 paddle_col  input  10  paddle left edge x.
REQ-012 paddle_row  input  10  paddle top edge y.
REQ-013 ball_x  output  10  ball left edge x.
REQ-014 ball_y  output  10  ball top edge y.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 hit  output  1  one-cycle pulse on paddle bounce.
REQ-017 miss  output  1  one-cycle pulse on bottom-edge miss.
REQ-018 hit_count  output  8  paddle bounces since start, saturating at 255.

Function
REQ-019 verticalSync SHALL pass through a two-flop synchronizer; frame_tick SHALL be a one-cycle pulse on a synchronized 1->0 transition.
REQ-020 FSM states SHALL be IDLE, WAIT_FRAME, MOVE, HIT_CHK, MISS.
REQ-021 IDLE: ball held at (COLS/2-BALL/2, ROWS/2-BALL/2) = (316,236), dir_x=+1, dir_y=+1; start -> WAIT_FRAME, hit_count cleared to 0 on the same edge.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 WAIT_FRAME: frame_tick with pause=0 -> MOVE; frame_tick with pause=1 SHALL be dropped, state unchanged.
REQ-024 frame_tick arriving in MOVE, HIT_CHK or MISS SHALL be dropped, not queued.
REQ-025 MOVE (one cycle) x: dir +1 and x+SPEED >= COLS-BALL -> x=COLS-BALL, dir_x=-1; dir -1 and x < SPEED -> x=0, dir_x=+1; else x±SPEED.
REQ-026 MOVE y: dir -1 and y < SPEED -> y=0, dir_y=+1; dir +1 and y+SPEED >= ROWS-BALL -> y=ROWS-BALL, dir_y unchanged; else y±SPEED; then -> HIT_CHK.
REQ-027 Intermediate sums SHALL use 11 bits; ball_x/ball_y SHALL never leave [0,COLS-BALL]/[0,ROWS-BALL].
REQ-028 HIT_CHK (one cycle) hit when dir_y=+1, y+BALL >= paddle_row, y < paddle_row+PADDLE_H, x+BALL > paddle_col, x < paddle_col+PADDLE_W.
REQ-029 On hit: y=paddle_row-BALL, dir_y=-1, hit=1, hit_count+1 (hold at 255), -> WAIT_FRAME.
REQ-030 Paddle hit SHALL take priority over miss in the same HIT_CHK cycle.
REQ-031 No hit and y = ROWS-BALL -> MISS; otherwise -> WAIT_FRAME.
REQ-032 MISS (one cycle): miss=1, ball recentered per REQ-021, hit_count retained, -> IDLE.
REQ-033 hit and miss SHALL never assert simultaneously.
REQ-034 ball_x, ball_y SHALL be registered, updating only on the clock edge leaving MOVE or HIT_CHK or MISS.

Reset
REQ-035 reset_n=0 SHALL, asynchronously and in any state, force IDLE, ball_x=316, ball_y=236, dir +1/+1, busy=0, hit=0, miss=0, hit_count=0, synchronizer flops=1.
REQ-036 Release of reset_n SHALL require a start pulse before any motion.

Verification
REQ-037 Reset, start, 3 vsync falls (pause=0), paddle at (0,470) -> ball (328,248), busy=1, no hit/miss.
REQ-038 Ball at x=628 dir +1, 1 frame -> ball_x=632, dir_x=-1; next frame ball_x=628.
REQ-039 Ball (300,468) dir_y=+1, paddle (290,476), 1 frame -> y=468, dir_y=-1, hit one cycle, hit_count=1 (paddle overrides bottom).
REQ-040 Paddle at (0,0), ball falls to y=472 -> miss one cycle, next cycle IDLE, ball (316,236), busy=0, hit_count retained.
REQ-041 pause=1 across 5 vsync falls -> ball unchanged; start pulse mid-play -> ignored.
REQ-042 reset_n asserted during MOVE -> outputs at REQ-035 values before next clk edge; hit_count=255 plus one more hit -> stays 255.
